image_read_8port: RTL and testbench

Video source for the DCT simulation/FPGA datapath and the counterpart of the 8-port image writer. It generates 1080p raster timing (vs/hs/de) at 8 pixels per clock. For every active clock it fetches one 8-pixel word from a synchronous pixel memory and presents it as 8 parallel RGB888 ports aligned with de. It sits at the head of the pipeline and feeds the DCT block under test.

---
 rtl/image_read_8port.sv | 196 +++++++++++++++++++
 tb/tb_image_read_8port.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_read_8port.sv
// rtl/image_read_8port.sv - 1080p raster source, 8 RGB888 pixels per clock from a synchronous pixel memory
// Optional feature macro: TEST_PATTERN_EN (internal 8-bar colour pattern, memory path unused)
module image_read_8port #(
  parameter int H_ACTIVE_CLK = 240,
  parameter int H_FP_CLK     = 11,
  parameter int H_SYNC_CLK   = 6,
  parameter int H_BP_CLK     = 18,
  parameter int V_ACTIVE     = 1080,
  parameter int V_FP         = 4,
  parameter int V_SYNC       = 5,
  parameter int V_BP         = 36,
  parameter int ADDR_W       = 18
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [191:0]      mem_rdata,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [7:0]        r_out_01, r_out_02, r_out_03, r_out_04,
  output logic [7:0]        r_out_05, r_out_06, r_out_07, r_out_08,
  output logic [7:0]        g_out_01, g_out_02, g_out_03, g_out_04,
  output logic [7:0]        g_out_05, g_out_06, g_out_07, g_out_08,
  output logic [7:0]        b_out_01, b_out_02, b_out_03, b_out_04,
  output logic [7:0]        b_out_05, b_out_06, b_out_07, b_out_08,
  output logic              frame_done
);

  localparam int H_TOTAL = H_ACTIVE_CLK + H_FP_CLK + H_SYNC_CLK + H_BP_CLK;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_DE_END = HW'(H_ACTIVE_CLK);
  localparam logic [HW-1:0] H_HS_BEG = HW'(H_ACTIVE_CLK + H_FP_CLK);
  localparam logic [HW-1:0] H_HS_END = HW'(H_ACTIVE_CLK + H_FP_CLK + H_SYNC_CLK);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_DE_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE_CLK * V_ACTIVE - 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            de0, hs0, vs0, fd0;
  logic            de1, hs1, vs1, fd1;
  logic [191:0]    pix_d, pix_q;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: a running frame always completes; en only matters at the frame boundary
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_RUN;
      S_RUN:   if (fd0 && !en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage-0 timing decode from the raster counters
  always_comb begin
    de0 = 1'b0;
    hs0 = 1'b0;
    vs0 = 1'b0;
    fd0 = 1'b0;
    if (state_q == S_RUN) begin
      de0 = (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
      hs0 = (h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END);
      vs0 = (v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END);
      fd0 = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end
  end

  // Raster position: held at zero while idle, wraps over the whole frame while running
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state_q != S_RUN) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Word address advances after every active read and returns to 0 after the last word of the frame
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                mem_addr <= '0;
    else if (state_q != S_RUN) mem_addr <= '0;
    else if (de0)              mem_addr <= (mem_addr == ADDR_LAST) ? '0 : mem_addr + ADDR_W'(1);
  end

  // Stage 1: timing delayed to line up with the memory read data
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      de1 <= 1'b0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      fd1 <= 1'b0;
    end else begin
      de1 <= de0;
      hs1 <= hs0;
      vs1 <= vs0;
      fd1 <= fd0;
    end
  end

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE_CLK / 8;

  logic [HW-1:0] h1;
  logic [2:0]    bar;
  logic [2:0]    rgb;
  logic          unused_rdata;

  assign mem_rd       = 1'b0;
  assign unused_rdata = ^mem_rdata;

  // Stage 1 copy of the horizontal position for the bar index
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) h1 <= '0;
    else        h1 <= h_cnt;
  end

  // Bars in order white, yellow, cyan, green, magenta, red, blue, black; all 8 pixels identical
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (32'(h1) >= i * BAR_W) bar = 3'(i);
    end
    case (bar)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    pix_d = '0;
    if (de1) pix_d = {8{{8{rgb[2]}}, {8{rgb[1]}}, {8{rgb[0]}}}};
  end
`else
  assign mem_rd = de0;

  // Memory word passes through only on active cycles; blanking outputs are black
  always_comb begin
    pix_d = '0;
    if (de1) pix_d = mem_rdata;
  end
`endif

  // Stage 2: every output registered on the same edge so timing and pixels stay aligned
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      de_out     <= 1'b0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      frame_done <= 1'b0;
      pix_q      <= '0;
    end else begin
      de_out     <= de1;
      hs_out     <= hs1;
      vs_out     <= vs1;
      frame_done <= fd1;
      pix_q      <= pix_d;
    end
  end

  assign r_out_01 = pix_q[23:16];   assign g_out_01 = pix_q[15:8];    assign b_out_01 = pix_q[7:0];
  assign r_out_02 = pix_q[47:40];   assign g_out_02 = pix_q[39:32];   assign b_out_02 = pix_q[31:24];
  assign r_out_03 = pix_q[71:64];   assign g_out_03 = pix_q[63:56];   assign b_out_03 = pix_q[55:48];
  assign r_out_04 = pix_q[95:88];   assign g_out_04 = pix_q[87:80];   assign b_out_04 = pix_q[79:72];
  assign r_out_05 = pix_q[119:112]; assign g_out_05 = pix_q[111:104]; assign b_out_05 = pix_q[103:96];
  assign r_out_06 = pix_q[143:136]; assign g_out_06 = pix_q[135:128]; assign b_out_06 = pix_q[127:120];
  assign r_out_07 = pix_q[167:160]; assign g_out_07 = pix_q[159:152]; assign b_out_07 = pix_q[151:144];
  assign r_out_08 = pix_q[191:184]; assign g_out_08 = pix_q[183:176]; assign b_out_08 = pix_q[175:168];

endmodule

// File: tb/tb_image_read_8port.sv
// tb/tb_image_read_8port.sv - testbench for image_read_8port on a reduced raster
module tb_image_read_8port;

  localparam int HA = 16, HFP = 3, HS = 2, HBP = 4;
  localparam int VA = 6, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int AT = HA * VA;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic en = 1'b0;
  logic mem_rd;
  logic [17:0] mem_addr;
  logic [191:0] mem_rdata = '0;
  logic vs_out, hs_out, de_out, frame_done;
  logic [7:0] r_out_01, r_out_02, r_out_03, r_out_04, r_out_05, r_out_06, r_out_07, r_out_08;
  logic [7:0] g_out_01, g_out_02, g_out_03, g_out_04, g_out_05, g_out_06, g_out_07, g_out_08;
  logic [7:0] b_out_01, b_out_02, b_out_03, b_out_04, b_out_05, b_out_06, b_out_07, b_out_08;
  logic [191:0] dut_pix;

  image_read_8port #(
    .H_ACTIVE_CLK(HA), .H_FP_CLK(HFP), .H_SYNC_CLK(HS), .H_BP_CLK(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .ADDR_W(18)
  ) dut (
    .clk(clk), .rst_b(rst_b), .en(en),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .r_out_01(r_out_01), .r_out_02(r_out_02), .r_out_03(r_out_03), .r_out_04(r_out_04),
    .r_out_05(r_out_05), .r_out_06(r_out_06), .r_out_07(r_out_07), .r_out_08(r_out_08),
    .g_out_01(g_out_01), .g_out_02(g_out_02), .g_out_03(g_out_03), .g_out_04(g_out_04),
    .g_out_05(g_out_05), .g_out_06(g_out_06), .g_out_07(g_out_07), .g_out_08(g_out_08),
    .b_out_01(b_out_01), .b_out_02(b_out_02), .b_out_03(b_out_03), .b_out_04(b_out_04),
    .b_out_05(b_out_05), .b_out_06(b_out_06), .b_out_07(b_out_07), .b_out_08(b_out_08),
    .frame_done(frame_done)
  );

  assign dut_pix = {r_out_08, g_out_08, b_out_08, r_out_07, g_out_07, b_out_07,
                    r_out_06, g_out_06, b_out_06, r_out_05, g_out_05, b_out_05,
                    r_out_04, g_out_04, b_out_04, r_out_03, g_out_03, b_out_03,
                    r_out_02, g_out_02, b_out_02, r_out_01, g_out_01, b_out_01};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory content: pixel k of word a has r=a+k, g=a+k+64, b=~(a+k)
  function automatic logic [191:0] mem_word(input logic [17:0] a);
    logic [191:0] w;
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b = a[7:0] + 8'(k);
      w[24*k +: 24] = {b, b + 8'd64, ~b};
    end
    return w;
  endfunction

  // Synchronous memory: data one clock after the read, junk otherwise
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_word(mem_addr);
    else        mem_rdata <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  end

  // Reference model: expected signals for frame position p, derived from the raster rules
  typedef struct {
    logic de, hs, vs, fd, rd;
    logic [17:0] addr;
    logic [191:0] pix;
  } exp_t;

  function automatic exp_t calc(input bit run, input int p);
    exp_t e;
    int h, v;
    h = p % HT;
    v = p / HT;
    e.de = run && h < HA && v < VA;
    e.hs = run && h >= HA + HFP && h < HA + HFP + HS;
    e.vs = run && v >= VA + VFP && v < VA + VFP + VS;
    e.fd = run && p == FT - 1;
    e.rd = e.de;
    e.addr = (run && v < VA) ? 18'((v * HA + (h < HA ? h : HA)) % AT) : 18'd0;
    e.pix = e.de ? mem_word(e.addr) : '0;
    return e;
  endfunction

  bit   m_run = 1'b0;
  int   m_p = 0;
  exp_t e_cur, e_mid, e_out;

  initial begin
    e_cur = calc(1'b0, 0);
    e_mid = e_cur;
    e_out = e_cur;
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_run = 1'b0;
      m_p = 0;
      e_cur = calc(1'b0, 0);
      e_mid = e_cur;
      e_out = e_cur;
    end else begin
      e_out = e_mid;
      e_mid = e_cur;
      if (m_run) begin
        if (m_p == FT - 1) begin
          m_p = 0;
          m_run = en;
        end else begin
          m_p++;
        end
      end else if (en) begin
        m_run = 1'b1;
        m_p = 0;
      end
      e_cur = calc(m_run, m_p);
    end
  end

  // Scoreboard: compare every cycle away from the active edge
  always @(negedge clk) begin
    chk("sb_de", 64'(de_out), 64'(e_out.de));
    chk("sb_hs", 64'(hs_out), 64'(e_out.hs));
    chk("sb_vs", 64'(vs_out), 64'(e_out.vs));
    chk("sb_frame_done", 64'(frame_done), 64'(e_out.fd));
    chk("sb_mem_rd", 64'(mem_rd), 64'(e_cur.rd));
    chk("sb_mem_addr", 64'(mem_addr), 64'(e_cur.addr));
    chkw("sb_pix", dut_pix, e_out.pix);
  end

  // Boundary vectors after reset release with en high: k = posedges since release
  typedef struct {
    int k;
    logic de, hs, vs, fd, rd;
    int addr;
    int r1;
  } vec_t;

  vec_t tbl[19];

  task automatic wait_first_de(input string name);
    int cnt;
    cnt = 0;
    while (!de_out && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, 64'(cnt), 64'd3);
  endtask

  initial begin
    int k;
    int de_cnt;
    int fd_cnt;

    tbl[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0};
    tbl[1]  = '{2,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1,  0};
    tbl[2]  = '{3,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2,  0};
    tbl[3]  = '{18,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16, 15};
    tbl[4]  = '{19,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 0};
    tbl[5]  = '{22,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16, 0};
    tbl[6]  = '{23,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16, 0};
    tbl[7]  = '{24,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16, 0};
    tbl[8]  = '{28,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18, 16};
    tbl[9]  = '{142, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  94};
    tbl[10] = '{143, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  95};
    tbl[11] = '{197, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  0};
    tbl[12] = '{202, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0};
    tbl[13] = '{203, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[14] = '{252, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,  0};
    tbl[15] = '{253, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,  0};
    tbl[16] = '{301, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0};
    tbl[17] = '{302, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1,  0};
    tbl[18] = '{303, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2,  0};

    // Reset held with en high: everything stays at zero
    repeat (3) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_de", 64'(de_out), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chkw("rst_pix", dut_pix, '0);

    // Release and walk the boundary table
    rst_b = 1'b1;
    k = 0;
    for (int i = 0; i < 19; i++) begin
      while (k < tbl[i].k) begin
        @(posedge clk);
        k++;
      end
      @(negedge clk);
      chk($sformatf("tbl%0d_de", tbl[i].k), 64'(de_out), 64'(tbl[i].de));
      chk($sformatf("tbl%0d_hs", tbl[i].k), 64'(hs_out), 64'(tbl[i].hs));
      chk($sformatf("tbl%0d_vs", tbl[i].k), 64'(vs_out), 64'(tbl[i].vs));
      chk($sformatf("tbl%0d_fd", tbl[i].k), 64'(frame_done), 64'(tbl[i].fd));
      chk($sformatf("tbl%0d_rd", tbl[i].k), 64'(mem_rd), 64'(tbl[i].rd));
      chk($sformatf("tbl%0d_addr", tbl[i].k), 64'(mem_addr), 64'(tbl[i].addr));
      chk($sformatf("tbl%0d_r01", tbl[i].k), 64'(r_out_01), 64'(tbl[i].r1));
    end

    // Random run requests, checked cycle by cycle by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(199, 0) == 0) en = ~en;
    end

    // Let any frame finish and the pipeline drain
    en = 1'b0;
    repeat (FT + 10) @(negedge clk);
    chk("idle_de", 64'(de_out), 64'd0);
    chk("idle_mem_rd", 64'(mem_rd), 64'd0);
    chk("idle_mem_addr", 64'(mem_addr), 64'd0);

    // Start, drop en early in the frame: the frame still completes exactly once
    en = 1'b1;
    wait_first_de("start_latency");
    de_cnt = 0;
    fd_cnt = 0;
    for (int i = 0; i < FT + 60; i++) begin
      if (de_out) de_cnt++;
      if (frame_done) fd_cnt++;
      if (i == 70) en = 1'b0;
      @(negedge clk);
    end
    chk("drop_de_count", 64'(de_cnt), 64'(AT));
    chk("drop_frame_done_count", 64'(fd_cnt), 64'd1);
    chk("drop_idle_hs", 64'(hs_out), 64'd0);
    chk("drop_idle_vs", 64'(vs_out), 64'd0);
    chk("drop_idle_mem_rd", 64'(mem_rd), 64'd0);
    chkw("drop_idle_pix", dut_pix, '0);

    // Re-enable: new frame from address 0
    en = 1'b1;
    wait_first_de("restart_latency");
    chk("restart_r01", 64'(r_out_01), 64'd0);
    chk("restart_g01", 64'(g_out_01), 64'd64);
    chk("restart_b01", 64'(b_out_01), 64'd255);
    chk("restart_r08", 64'(r_out_08), 64'd7);
    chk("restart_addr", 64'(mem_addr), 64'd2);

    // Asynchronous reset mid-frame
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_de", 64'(de_out), 64'd0);
    chk("arst_mem_rd", 64'(mem_rd), 64'd0);
    chk("arst_mem_addr", 64'(mem_addr), 64'd0);
    chkw("arst_pix", dut_pix, '0);
    repeat (3) @(negedge clk);
    en = 1'b0;
    rst_b = 1'b1;
    repeat (5) @(negedge clk);
    chk("arst_wait_de", 64'(de_out), 64'd0);
    chk("arst_wait_rd", 64'(mem_rd), 64'd0);
    en = 1'b1;
    wait_first_de("arst_restart_latency");
    en = 1'b0;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
